// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DIGIT_W     = 4;
   localparam int unsigned CORR_THRESH = 8;
   localparam int unsigned CORR_SUB    = 3;

   // Smallest binary width w with 2^w > 10^digits - 1.
   function automatic int unsigned min_bin_w(input int unsigned digits);
      longint unsigned lim;
      int unsigned     w;
      lim = 1;
      w   = 0;
      for (int unsigned i = 0; i < digits; i++) lim = lim * 10;
      while ((64'd1 << w) < lim) w++;
      return w;
   endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Handshake bundle for bcd_to_binary: BCD request side and binary result side.
interface bcd_to_binary_if
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned BIN_W  = 7
);
   localparam int unsigned BCD_W = DIGIT_W * DIGITS;

   logic             in_valid;
   logic             in_ready;
   logic [BCD_W-1:0] bcd_in;
   logic             out_valid;
   logic             out_ready;
   logic [BIN_W-1:0] bin_out;
   logic             bcd_err;

   modport master (
      output in_valid, bcd_in, out_ready,
      input  in_ready, out_valid, bin_out, bcd_err
   );

   modport slave (
      input  in_valid, bcd_in, out_ready,
      output in_ready, out_valid, bin_out, bcd_err
   );
endinterface

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction step: subtract 3 when the digit is 8 or more.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] din,
   output logic [DIGIT_W-1:0] dout
);

   always_comb begin
      dout = din;
      if (din >= DIGIT_W'(CORR_THRESH)) dout = din - DIGIT_W'(CORR_SUB);
   end

endmodule

// File: rtl/bcd_to_binary.sv
// Iterative reverse double-dabble converter, one bit per clock.
// Optional input digit checking is enabled by defining BCD_CHECK_EN.
module bcd_to_binary
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned BIN_W  = min_bin_w(DIGITS)
) (
   input logic            clk,
   input logic            reset,
   bcd_to_binary_if.slave bus
);

   localparam int unsigned BCD_W  = DIGIT_W * DIGITS;
   localparam int unsigned ITER_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   state_t            state;
   logic [BCD_W-1:0]  bcd_reg;
   logic [BCD_W-1:0]  bcd_shift;
   logic [BCD_W-1:0]  bcd_adj;
   logic [BIN_W-1:0]  bin_reg;
   logic [ITER_W-1:0] iter;
   logic              in_ready_r;
   logic              out_valid_r;

   assign bcd_shift = bcd_reg >> 1;

   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .din  (bcd_shift[g*DIGIT_W +: DIGIT_W]),
         .dout (bcd_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

`ifdef BCD_CHECK_EN
   logic bad_digit;
   logic bcd_err_r;

   always_comb begin
      bad_digit = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bus.bcd_in[i*DIGIT_W +: DIGIT_W] > 4'd9) bad_digit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bcd_err_r <= 1'b0;
      end else if (state == IDLE && bus.in_valid && in_ready_r) begin
         bcd_err_r <= bad_digit;
      end else if (state == DONE && bus.out_ready) begin
         bcd_err_r <= 1'b0;
      end
   end

   assign bus.bcd_err = bcd_err_r;
`else
   assign bus.bcd_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         bcd_reg     <= '0;
         bin_reg     <= '0;
         iter        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               in_ready_r <= 1'b1;
               if (bus.in_valid && in_ready_r) begin
                  bcd_reg    <= bus.bcd_in;
                  bin_reg    <= '0;
                  iter       <= '0;
                  in_ready_r <= 1'b0;
                  state      <= CONV;
               end
            end
            CONV: begin
               // BCD LSB moves into the binary MSB; digits are corrected after the shift.
               bcd_reg <= bcd_adj;
               bin_reg <= {bcd_reg[0], bin_reg[BIN_W-1:1]};
               iter    <= iter + 1'b1;
               if (iter == ITER_W'(BIN_W - 1)) begin
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.bin_out   = bin_reg;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed cases plus random traffic vs a decimal model.
module tb_bcd_to_binary;

   localparam int unsigned DIGITS = 2;
   localparam int unsigned BIN_W  = 7;

   typedef struct {
      int unsigned val;
      bit          err;
      bit          dc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   bit   prev_ov = 1'b0;
   bit   rand_ready = 1'b0;
   exp_t exp_q[$];

   bcd_to_binary_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

   bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   function automatic int unsigned bcd_value(input logic [7:0] w);
      int unsigned v = 0;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) v = v * 10 + int'(w[k*4 +: 4]);
      return v;
   endfunction

   function automatic bit bcd_bad(input logic [7:0] w);
      bit b = 1'b0;
      for (int k = 0; k < int'(DIGITS); k++) if (w[k*4 +: 4] > 4'd9) b = 1'b1;
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Compare process: every cycle, outputs against the model queue.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         exp_q.delete();
         prev_ov = 1'b0;
         chk("rst_in_ready", 32'(bus.in_ready), 0);
         chk("rst_out_valid", 32'(bus.out_valid), 0);
         chk("rst_bin_out", 32'(bus.bin_out), 0);
         chk("rst_bcd_err", 32'(bus.bcd_err), 0);
      end else begin
         if (bus.out_valid) begin
            chk("out_has_expected", 32'(exp_q.size() != 0), 1);
            chk("in_ready_in_done", 32'(bus.in_ready), 0);
            if (exp_q.size() != 0) begin
               e = exp_q[0];
               if (!prev_ov) chk("latency", 32'(cyc - accept_cyc), BIN_W);
               if (!e.dc) chk("bin_out", 32'(bus.bin_out), e.val);
               chk("bcd_err", 32'(bus.bcd_err), 32'(e.err));
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            e.val = bcd_value(bus.bcd_in);
`ifdef BCD_CHECK_EN
            e.err = bcd_bad(bus.bcd_in);
`else
            e.err = 1'b0;
`endif
            e.dc  = bcd_bad(bus.bcd_in);
            exp_q.push_back(e);
            accept_cyc = cyc + 1;
         end
         prev_ov = bus.out_valid;
      end
   end

   task automatic send(input logic [7:0] w);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.bcd_in   = w;
      while (!bus.in_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.in_ready) chk("send_timeout", 32'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      while (!bus.out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.out_valid) chk("wait_out_timeout", 32'(bus.out_valid), 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!bus.in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.in_ready) chk("wait_idle_timeout", 32'(bus.in_ready), 1);
   endtask

   initial begin
      logic [7:0] w;
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.bcd_in    = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      // 45 decimal
      send(8'h45);
      wait_out();
      chk("h45_bin", 32'(bus.bin_out), 32'h2D);
      chk("h45_err", 32'(bus.bcd_err), 0);
      wait_idle();

      // Full sweep of valid codes, back to back
      for (int i = 0; i < 100; i++) begin
         w[7:4] = 4'(i / 10);
         w[3:0] = 4'(i % 10);
         send(w);
         if (i == 0) begin
            wait_out();
            chk("h00_bin", 32'(bus.bin_out), 0);
         end
         if (i == 99) begin
            wait_out();
            chk("h99_bin", 32'(bus.bin_out), 32'h63);
         end
      end
      wait_idle();

      // Stall with out_ready low
      bus.out_ready = 1'b0;
      send(8'h12);
      wait_out();
      repeat (20) begin
         @(posedge clk);
         #1;
         chk("stall_valid", 32'(bus.out_valid), 1);
         chk("stall_bin", 32'(bus.bin_out), 32'h0C);
         chk("stall_in_ready", 32'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_hs_valid", 32'(bus.out_valid), 0);
      chk("post_hs_in_ready", 32'(bus.in_ready), 1);

      // Reset during conversion discards the result
      send(8'h78);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("midrst_valid", 32'(bus.out_valid), 0);
      chk("midrst_bin", 32'(bus.bin_out), 0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("midrst_hold_valid", 32'(bus.out_valid), 0);
      end
      reset = 1'b1;
      send(8'h78);
      wait_out();
      chk("h78_bin", 32'(bus.bin_out), 32'h4E);
      wait_idle();

      // Input activity during conversion is ignored
      send(8'h56);
      bus.in_valid = 1'b1;
      bus.bcd_in   = 8'h99;
      repeat (3) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_out();
      chk("h56_inflight_bin", 32'(bus.bin_out), 56);
      wait_idle();

      // Invalid digit
      send(8'h3A);
      wait_out();
`ifdef BCD_CHECK_EN
      chk("h3A_err", 32'(bus.bcd_err), 1);
`else
      chk("h3A_err", 32'(bus.bcd_err), 0);
`endif
      wait_idle();

      // Random traffic with random backpressure
      rand_ready = 1'b1;
      repeat (150) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         w[7:4] = 4'($urandom_range(0, 9));
         w[3:0] = 4'($urandom_range(0, 9));
         send(w);
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      wait_idle();
      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential reverse double-dabble converter: packed BCD in, unsigned binary out. It is the decode-side counterpart of the binary-to-BCD converter.
- Used on display/keypad paths where operator-entered decimal digits return to arithmetic datapaths.
- Iterative shift/correct engine, one bit per clock, with valid/ready handshake on both sides.

Parameters:
- DIGITS, 2, number of BCD digits on input (1..8).
- BCD_W, 4*DIGITS, packed BCD input width (derived, not overridden).
- BIN_W, 7, binary output width; must satisfy 2^BIN_W > 10^DIGITS - 1 (7 for DIGITS=2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  BCD word present.
- in_ready  output  1  converter idle, will accept.
- bcd_in  input  BCD_W  packed BCD; digit 0 in bits [3:0].
- out_valid  output  1  result held on bin_out.
- out_ready  input  1  sink accepts result.
- bin_out  output  BIN_W  converted binary value.
- bcd_err  output  1  input contained a digit > 9 (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, in_ready=0 while asserted, out_valid=0, bin_out=0, bcd_err=0, shift and iteration counters cleared.
- States are IDLE, CONV and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: load bcd_in into the BCD shift register, clear the binary register, set iter=0, go to CONV.
- CONV (in_ready=0). Each clock:
  - Shift {bcd_reg, bin_reg} right by 1; the BCD LSB enters the bin_reg MSB.
  - Then, per digit of the shifted bcd_reg: if digit >= 8, subtract 3 (4-bit, no borrow between digits).
  - iter increments. When iter reaches BIN_W-1 on the shifting edge, go to DONE.
- Latency: out_valid rises exactly BIN_W clocks after the accepting edge (7 for defaults).
- DONE:
  - out_valid=1 and bin_out holds the result.
  - bin_out and out_valid stay stable until out_valid&&out_ready.
  - On that edge: out_valid=0, go to IDLE.
  - in_ready stays 0 in DONE; there is no overlap of the next accept with the result handshake, so throughput is one word per BIN_W+2 clocks minimum.
- out_ready held low indefinitely: the block stalls in DONE and input is not accepted.
- in_valid ignored outside IDLE; bcd_in is sampled only on the accepting edge, so later changes have no effect.
- Reset mid-CONV or mid-DONE: immediate return to reset values; the partial result is discarded and never presented.
- Result is exact for all valid BCD inputs 0..10^DIGITS-1. The BCD register is zero after the final shift.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - On the accepting edge, bcd_err is registered as OR over digits of (digit > 9).
  - Conversion still runs; bin_out is then don't-care.
  - bcd_err is valid alongside out_valid and clears on the out handshake or reset.
- Undefined: bcd_err tied 0; no digit comparators synthesized; invalid digits give an unspecified bin_out.

Decomposition:
- Shared package/header bcd_pkg:
  - state encodings IDLE/CONV/DONE;
  - DIGIT_W=4;
  - CORR_THRESH=8 and CORR_SUB=3;
  - a constant function computing the minimum BIN_W for a given DIGITS.
- One sub-module, bcd_digit_adjust: 4-bit combinational "subtract 3 if >= 8", instantiated DIGITS times via generate.

Test Plan:
- Reset, then bcd_in=8'h45 with in_valid: out_valid exactly 7 clocks after accept; bin_out=7'h2D; bcd_err=0.
- Sweep 8'h00..8'h99 valid codes back-to-back with out_ready=1: bin_out equals the decimal value each time (8'h99 gives 7'h63, 8'h00 gives 0).
- bcd_in=8'h12, out_ready=0 for 20 clocks: out_valid and bin_out=7'h0C held stable and in_ready=0 throughout. Raise out_ready: one handshake, then in_ready=1 next cycle.
- Assert reset low 3 clocks after accepting 8'h78: out_valid never asserts, all outputs at reset values. After release, 8'h78 gives 7'h4E.
- With BCD_CHECK_EN: bcd_in=8'h3A gives bcd_err=1 with out_valid. Without the macro: bcd_err stays 0.
- Change bcd_in and pulse in_valid during CONV: no effect on the in-flight result.
